// File: rtl/riscky_pkg.sv
// Shared constants for the riscky memory-access stage: FSM state encoding,
// operation codes and default bus/timeout sizes.
package riscky_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/riscky_mem_interface_if.sv
// Request/acknowledge bus between the memory-access stage (master) and a
// variable-latency memory (slave).
interface riscky_mem_interface_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/riscky_mem_timeout.sv
// REQ-phase cycle counter; expired flags the TIMEOUT_CYC-th consecutive REQ
// cycle so the FSM can abandon the access at the end of it.
module riscky_mem_timeout
  import riscky_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= '0;
    end else if (active && (count != CNT_W'(TIMEOUT_CYC))) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of REQ cycles already completed
  assign expired = active && (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/riscky_mem_interface.sv
// Memory-access stage: turns control-unit strobes into a req/ack transaction,
// holds the MDR and reports busy/done/err. Optional timeout: RISCKY_MEM_TIMEOUT_EN.
module riscky_mem_interface
  import riscky_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemRead,
  input  logic                   MemWrite,
  input  logic                   MDRwrite,
  input  logic [ADDR_W-1:0]      addr_in,
  input  logic [DATA_W-1:0]      wdata_in,
  riscky_mem_interface_if.master mem,
  output logic [DATA_W-1:0]      mdr_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  mem_state_t        state;
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              mdr_cap;
  logic              strobe_one;
  logic              strobe_both;
  logic              strobe_any;
  logic              enter_req;
  logic              timeout_hit;

  assign strobe_one  = MemRead ^ MemWrite;
  assign strobe_both = MemRead & MemWrite;
  assign strobe_any  = MemRead | MemWrite;
  assign enter_req   = (state != MEM_REQ) && strobe_one;

`ifdef RISCKY_MEM_TIMEOUT_EN
  riscky_mem_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .start  (enter_req),
    .active (state == MEM_REQ),
    .expired(timeout_hit)
  );
`else
  // Without the timeout REQ waits for mem_ack indefinitely.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MEM_IDLE;
      req     <= 1'b0;
      we      <= MEM_OP_READ;
      addr    <= '0;
      wdata   <= '0;
      mdr_cap <= 1'b0;
      mdr_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new strobe exactly like IDLE so back-to-back
        // accesses issue without a gap cycle.
        MEM_IDLE, MEM_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          req  <= 1'b0;
          if (mem.ack) begin
            err <= 1'b1;
          end
          if (strobe_both) begin
            err   <= 1'b1;
            state <= MEM_IDLE;
          end else if (enter_req) begin
            state   <= MEM_REQ;
            req     <= 1'b1;
            busy    <= 1'b1;
            we      <= MemWrite ? MEM_OP_WRITE : MEM_OP_READ;
            addr    <= addr_in;
            wdata   <= wdata_in;
            mdr_cap <= MDRwrite;
          end else begin
            state <= MEM_IDLE;
          end
        end
        MEM_REQ: begin
          if (strobe_any) begin
            err <= 1'b1;
          end
          if (mem.ack) begin
            if ((we == MEM_OP_READ) && mdr_cap) begin
              mdr_out <= mem.rdata;
            end
            state <= MEM_DONE;
            req   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (timeout_hit) begin
            err   <= 1'b1;
            state <= MEM_DONE;
            req   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= MEM_IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.req   = req;
  assign mem.we    = we;
  assign mem.addr  = addr;
  assign mem.wdata = wdata;

endmodule

// File: tb/tb_riscky_mem_interface.sv
// Self-checking bench for riscky_mem_interface: per-cycle vector table plus
// hand-written long-wait / timeout sequences (RISCKY_MEM_TIMEOUT_EN).
module tb_riscky_mem_interface;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic        mdrw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        e_req;
    logic        e_we;
    logic        chk_bus;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_mdr;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic        MDRwrite;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic [15:0] mdr_out;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  int row    = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  riscky_mem_interface_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

  riscky_mem_interface #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .MDRwrite(MDRwrite),
    .addr_in (addr_in),
    .wdata_in(wdata_in),
    .mem     (mem_bus),
    .mdr_out (mdr_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int rd, input int wr, input int mw,
                              input int a, input int wd, input int ak, input int rdt,
                              input int req, input int we, input int cb,
                              input int ea, input int ew, input int em,
                              input int bsy, input int dn, input int er);
    vec_t v;
    v.rst     = 1'(r);
    v.rd      = 1'(rd);
    v.wr      = 1'(wr);
    v.mdrw    = 1'(mw);
    v.addr    = 16'(a);
    v.wdata   = 16'(wd);
    v.ack     = 1'(ak);
    v.rdata   = 16'(rdt);
    v.e_req   = 1'(req);
    v.e_we    = 1'(we);
    v.chk_bus = 1'(cb);
    v.e_addr  = 16'(ea);
    v.e_wdata = 16'(ew);
    v.e_mdr   = 16'(em);
    v.e_busy  = 1'(bsy);
    v.e_done  = 1'(dn);
    v.e_err   = 1'(er);
    return v;
  endfunction

  // One cycle: drive inputs mid-cycle, then check the registered outputs of this cycle.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    logic ok;
    @(negedge clk);
    rst           = v.rst;
    MemRead       = v.rd;
    MemWrite      = v.wr;
    MDRwrite      = v.mdrw;
    addr_in       = v.addr;
    wdata_in      = v.wdata;
    mem_bus.ack   = v.ack;
    mem_bus.rdata = v.rdata;
    exp_q.push_back(v);
    #1;
    e  = exp_q.pop_front();
    ok = (mem_bus.req === e.e_req) && (mdr_out === e.e_mdr) && (busy === e.e_busy) &&
         (done === e.e_done) && (err === e.e_err);
    if (e.chk_bus)
      ok = ok && (mem_bus.we === e.e_we) && (mem_bus.addr === e.e_addr) &&
           (mem_bus.wdata === e.e_wdata);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s row %0d: got req=%b we=%b addr=%h wdata=%h mdr=%h busy=%b done=%b err=%b; want req=%b we=%b addr=%h wdata=%h (bus checked=%b) mdr=%h busy=%b done=%b err=%b",
               tag, row, mem_bus.req, mem_bus.we, mem_bus.addr, mem_bus.wdata, mdr_out,
               busy, done, err, e.e_req, e.e_we, e.e_addr, e.e_wdata, e.chk_bus,
               e.e_mdr, e.e_busy, e.e_done, e.e_err);
    end
    row++;
  endtask

  initial begin
    // read, zero wait
    tbl.push_back(mk(0,1,0,1,'h0040,0,0,0,           0,0,1,0,0,0,            0,0,0));
    tbl.push_back(mk(0,0,0,0,'h0040,0,1,'hBEEF,      1,0,1,'h0040,0,0,       1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,'hBEEF,       0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,'hBEEF,       0,0,0));
    // write, 3 wait states, addr_in/wdata_in disturbed during REQ
    tbl.push_back(mk(0,0,1,0,'h0102,'h1234,0,0,      0,0,0,0,0,'hBEEF,       0,0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0,'hFFFF,'hFFFF,0,0,    1,1,1,'h0102,'h1234,'hBEEF, 1,0,0));
    tbl.push_back(mk(0,0,0,0,'hFFFF,'hFFFF,1,'h5555, 1,1,1,'h0102,'h1234,'hBEEF, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,'hBEEF,       0,1,0));
    // back-to-back reads, second strobe in DONE
    tbl.push_back(mk(0,1,0,1,'h0200,0,0,0,           0,0,0,0,0,'hBEEF,       0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h1111,           1,0,1,'h0200,0,'hBEEF,  1,0,0));
    tbl.push_back(mk(0,1,0,1,'h0300,0,0,0,           0,0,0,0,0,'h1111,       0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h2222,           1,0,1,'h0300,0,'h1111,  1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,'h2222,       0,1,0));
    // read with MDRwrite=0 leaves MDR alone
    tbl.push_back(mk(0,1,0,0,'h0400,0,0,0,           0,0,0,0,0,'h2222,       0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h3333,           1,0,1,'h0400,0,'h2222,  1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,'h2222,       0,1,0));
    // both strobes in IDLE
    tbl.push_back(mk(0,1,1,0,'h0500,0,0,0,           0,0,0,0,0,'h2222,       0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,'h2222,       0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,1,'h0400,0,'h2222,  0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                0,0,0,0,0,'h2222,       0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,1,0,0,0,            0,0,0));
    // strobe during REQ
    tbl.push_back(mk(0,1,0,1,'h0600,0,0,0,           0,0,1,0,0,0,            0,0,0));
    tbl.push_back(mk(0,0,1,0,'h0700,'hAAAA,0,0,      1,0,1,'h0600,0,0,       1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h4444,           1,0,1,'h0600,0,0,       1,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,'h4444,       0,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                0,0,0,0,0,'h4444,       0,0,1));
    // stray ack in IDLE
    tbl.push_back(mk(0,0,0,0,0,0,1,'h6666,           0,0,1,0,0,0,            0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,0,            0,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                0,0,0,0,0,0,            0,0,1));
    // reset in the second REQ cycle, late ack afterwards
    tbl.push_back(mk(0,1,0,1,'h0800,0,0,0,           0,0,1,0,0,0,            0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                1,0,1,'h0800,0,0,       1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,                1,0,1,'h0800,0,0,       1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h9999,           0,0,1,0,0,0,            0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,                0,0,0,0,0,0,            0,0,1));

    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MDRwrite = 1'b0;
    addr_in = '0; wdata_in = '0; mem_bus.ack = 1'b0; mem_bus.rdata = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) step(tbl[i], "table");

`ifdef RISCKY_MEM_TIMEOUT_EN
    // TIMEOUT_CYC=4: unanswered read abandoned after 4 REQ cycles
    step(mk(1,0,0,0,0,0,0,0,          0,0,0,0,0,0,            0,0,1), "to_rst");
    step(mk(0,1,0,1,'h0A00,0,0,0,     0,0,1,0,0,0,            0,0,0), "to_load");
    step(mk(0,0,0,0,0,0,1,'h7777,     1,0,1,'h0A00,0,0,       1,0,0), "to_load");
    step(mk(0,1,0,1,'h0B00,0,0,0,     0,0,0,0,0,'h7777,       0,1,0), "to_start");
    for (int i = 0; i < 4; i++)
      step(mk(0,0,0,0,0,0,0,0,        1,0,1,'h0B00,0,'h7777,  1,0,0), "to_wait");
    step(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0,'h7777,       0,1,1), "to_expire");
    step(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0,'h7777,       0,0,1), "to_after");
    // ack on the 4th REQ cycle wins over expiry
    step(mk(1,0,0,0,0,0,0,0,          0,0,0,0,0,'h7777,       0,0,1), "to_rst");
    step(mk(0,1,0,1,'h0C00,0,0,0,     0,0,1,0,0,0,            0,0,0), "ack_last");
    for (int i = 0; i < 3; i++)
      step(mk(0,0,0,0,0,0,0,0,        1,0,1,'h0C00,0,0,       1,0,0), "ack_last");
    step(mk(0,0,0,0,0,0,1,'h5A5A,     1,0,1,'h0C00,0,0,       1,0,0), "ack_last");
    step(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0,'h5A5A,       0,1,0), "ack_last_done");
    step(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0,'h5A5A,       0,0,0), "ack_last_idle");
`else
    // without the timeout a slow memory is simply waited for
    step(mk(1,0,0,0,0,0,0,0,          0,0,0,0,0,0,            0,0,1), "long_rst");
    step(mk(0,1,0,1,'h0D00,0,0,0,     0,0,1,0,0,0,            0,0,0), "long_start");
    for (int i = 0; i < 10; i++)
      step(mk(0,0,0,0,0,0,0,0,        1,0,1,'h0D00,0,0,       1,0,0), "long_wait");
    step(mk(0,0,0,0,0,0,1,'h0E0E,     1,0,1,'h0D00,0,0,       1,0,0), "long_ack");
    step(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0,'h0E0E,       0,1,0), "long_done");
    step(mk(0,0,0,0,0,0,0,0,          0,0,0,0,0,'h0E0E,       0,0,0), "long_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscky_mem_interface.md
Name: riscky_mem_interface

Overview:
- Memory-access stage directly downstream of the multi-cycle control unit.
- Converts the one-cycle MemRead/MemWrite/MDRwrite strobes into a request/acknowledge transaction with a variable-latency memory.
- Holds the Memory Data Register (MDR) and reports busy/done so the sequencer can hold its state until the access completes.

Parameters:
- DATA_W, 16, data bus and MDR width.
- ADDR_W, 16, memory address width.
- TIMEOUT_CYC, 64, maximum cycles a request waits for mem_ack (used only with RISCKY_MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  control-unit read strobe.
- MemWrite  in  1  control-unit write strobe.
- MDRwrite  in  1  enables MDR capture of read data.
- addr_in  in  ADDR_W  address from ALUout.
- wdata_in  in  DATA_W  store data from register B.
- mem_req  out  1  request to memory.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_ack  in  1  memory completion; one cycle, only meaningful while mem_req=1.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- mdr_out  out  DATA_W  MDR contents to the register-file write mux.
- busy  out  1  transaction in flight (registered).
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all outputs 0; mdr_out=0; latched addr/data=0. rst mid-transaction aborts immediately; mem_req=0 on the next cycle and no done.
- State machine:
  - IDLE: MemRead xor MemWrite sampled at edge N -> latch addr_in/wdata_in/op, go REQ.
    - MemRead and MemWrite both 1 -> stay IDLE, set err, no request.
  - REQ: mem_req=1, mem_we=op, busy=1. Stays until mem_ack=1.
    - On the ack edge M: for reads with the MDRwrite captured at request time =1, mdr_out<=mem_rdata.
    - Go DONE.
  - DONE: done=1, busy=0, mem_req=0 for exactly one cycle, then IDLE.
    - A new strobe in DONE is accepted as if in IDLE, so back-to-back accesses lose no cycle.
- Latency: mem_req rises at N+1. Minimum strobe-to-done is 2 cycles (ack in first REQ cycle). mdr_out is valid from the DONE cycle onward and holds until the next captured read.
- busy is 1 exactly in REQ cycles.
- Strobes arriving while in REQ are ignored and set err (overrun). The outstanding transaction is unaffected.
- Writes never modify mdr_out. A read with MDRwrite=0 completes normally and leaves mdr_out unchanged.
- mem_ack outside REQ is ignored and sets err.
- err clears only on rst.
- mem_addr/mem_wdata stay stable throughout REQ regardless of addr_in/wdata_in changes.

Optional Feature:
- Macro RISCKY_MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter (width clog2(TIMEOUT_CYC+1)) clears on entry to REQ and increments each REQ cycle.
  - If it reaches TIMEOUT_CYC without mem_ack: drop mem_req, set err, go DONE with done=1, mdr_out unchanged.
  - mem_ack in the same cycle as the count reaching TIMEOUT_CYC takes priority; the access completes normally.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Shared package riscky_pkg:
  - state encoding constants for MEM_IDLE/MEM_REQ/MEM_DONE;
  - MEM_OP_READ/MEM_OP_WRITE constants;
  - default DATA_W/ADDR_W;
  - TIMEOUT_CYC default.
- One natural sub-module: riscky_mem_timeout (counter + expiry flag), instantiated only under RISCKY_MEM_TIMEOUT_EN.

Test Plan:
- Read, zero wait: addr_in=0x0040, MemRead=1, MDRwrite=1 at cycle 0; memory acks at cycle 1 with 0xBEEF.
  - Expect mem_req=1 in cycle 1 only, mem_we=0, mem_addr=0x0040.
  - Expect done=1 at cycle 2 and mdr_out=0xBEEF from cycle 2.
- Write, 3 wait states: MemWrite=1, addr 0x0102, data 0x1234; addr_in changes to 0xFFFF at cycle 1; ack at cycle 4.
  - Expect mem_we=1, mem_addr=0x0102 stable in cycles 1-4, done at 5, mdr_out unchanged.
- Back-to-back: read strobe issued in the DONE cycle of the previous access.
  - Expect mem_req=1 the following cycle, no idle gap, both done pulses seen.
- Protocol errors:
  - MemRead=MemWrite=1 in IDLE -> no mem_req, err=1.
  - Strobe during REQ -> ignored, err=1, original transaction completes.
  - Stray mem_ack in IDLE -> err=1.
- Reset mid-transaction: rst=1 in the second REQ cycle.
  - Expect mem_req=0, busy=0, done=0, err=0, mdr_out=0 next cycle; a later ack is ignored.
- Timeout (RISCKY_MEM_TIMEOUT_EN, TIMEOUT_CYC=4): read with no ack.
  - Expect mem_req high 4 cycles, then done=1, err=1, mdr_out unchanged.
  - Ack on the 4th cycle -> normal completion, err=0.
